// File: rtl/inst_queue_pkg.sv
// Shared types and widths for the fetch-to-decode instruction queue.
package inst_queue_pkg;

    localparam int IQ_DEPTH   = 8;
    localparam int IQ_FETCH_W = 2;
    localparam int IQ_ISSUE_W = 2;
    localparam int IQ_DATA_W  = 64;

    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = $clog2(IQ_DEPTH + 1);
    localparam int ACC_W = $clog2(IQ_ISSUE_W + 1);

    typedef struct packed {
        logic                 bd;
        logic [IQ_DATA_W-1:0] data;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side enqueue lanes, decode-side issue window and flush controls of the queue.
interface inst_queue_if
    import inst_queue_pkg::*;
#(
    parameter int DEPTH   = IQ_DEPTH,
    parameter int FETCH_W = IQ_FETCH_W,
    parameter int ISSUE_W = IQ_ISSUE_W,
    parameter int DATA_W  = IQ_DATA_W
) ();

    logic [FETCH_W-1:0]                     in_valid;
    logic [FETCH_W-1:0][DATA_W-1:0]         in_data;
    logic [FETCH_W-1:0]                     in_bd;
    logic                                   in_ready;
    logic [ISSUE_W-1:0]                     out_valid;
    logic [ISSUE_W-1:0][DATA_W-1:0]         out_data;
    logic [ISSUE_W-1:0]                     out_bd;
    logic [$clog2(ISSUE_W+1)-1:0]           out_accept;
    logic                                   flush;
    logic                                   bpu_flush;
    logic [$clog2(DEPTH+1)-1:0]             occupancy;

    modport master (
        output in_valid, in_data, in_bd, out_accept, flush, bpu_flush,
        input  in_ready, out_valid, out_data, out_bd, occupancy
    );

    modport slave (
        input  in_valid, in_data, in_bd, out_accept, flush, bpu_flush,
        output in_ready, out_valid, out_data, out_bd, occupancy
    );

endinterface

// File: rtl/inst_queue_chk.sv
// Protocol checks on the decode accept count and the packed fetch lanes.
module inst_queue_chk
    import inst_queue_pkg::*;
#(
    parameter int FETCH_W = IQ_FETCH_W,
    parameter int AW      = ACC_W
) (
    input logic               clk,
    input logic               reset,
    input logic [CNT_W-1:0]   occupancy,
    input logic [AW-1:0]      out_accept,
    input logic [FETCH_W-1:0] in_valid
);

    a_accept_le_valid: assert property (@(posedge clk) disable iff (reset)
        (CNT_W'(out_accept) <= occupancy));

    // A packed lane mask has the form 0..01..1, so adding one clears every set bit.
    a_lanes_packed: assert property (@(posedge clk) disable iff (reset)
        ((in_valid & (in_valid + FETCH_W'(1))) == {FETCH_W{1'b0}}));

endmodule

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode with full and mispredict flush.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH   = IQ_DEPTH,
    parameter int FETCH_W = IQ_FETCH_W,
    parameter int ISSUE_W = IQ_ISSUE_W,
    parameter int DATA_W  = IQ_DATA_W
) (
    input logic        clk,
    input logic        reset,
    inst_queue_if.slave iq
);

    localparam int AW = $clog2(ISSUE_W + 1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    iq_entry_t        mem_q [DEPTH];
    iq_entry_t        mem_d [DEPTH];

    logic             in_ready_s;
    logic             enq_fire_s;
    logic [CNT_W-1:0] enq_cnt_s;
    logic [CNT_W-1:0] enq_add_s;
    logic [CNT_W-1:0] deq_cnt_s;
    logic [CNT_W-1:0] rem_cnt_s;
    logic [PTR_W-1:0] head_adv_s;

    // Conservative ready: only the registered count is used, never this cycle's accept.
    assign in_ready_s = (count_q <= CNT_W'(DEPTH - FETCH_W));
    assign enq_fire_s = in_ready_s & ~iq.flush & ~iq.bpu_flush;

    // Enqueue lane count and pointer position after this cycle's dequeue.
    always_comb begin
        enq_cnt_s = {CNT_W{1'b0}};
        for (int i = 0; i < FETCH_W; i++) begin
            enq_cnt_s = enq_cnt_s + CNT_W'(iq.in_valid[i]);
        end
        enq_add_s  = enq_fire_s ? enq_cnt_s : {CNT_W{1'b0}};
        deq_cnt_s  = CNT_W'(iq.out_accept);
        rem_cnt_s  = count_q - deq_cnt_s;
        head_adv_s = head_q + PTR_W'(iq.out_accept);
    end

    // Pointer/count next state: flush beats mispredict flush beats normal traffic.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (iq.flush) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else if (iq.bpu_flush) begin
            head_d = head_adv_s;
            // A delay slot already at the head after dequeue survives the mispredict.
            if ((rem_cnt_s != {CNT_W{1'b0}}) && mem_q[head_adv_s].bd) begin
                tail_d  = head_adv_s + PTR_W'(1);
                count_d = CNT_W'(1);
            end else begin
                tail_d  = head_adv_s;
                count_d = {CNT_W{1'b0}};
            end
        end else begin
            head_d  = head_adv_s;
            tail_d  = tail_q + PTR_W'(enq_add_s);
            count_d = count_q + enq_add_s - deq_cnt_s;
        end
    end

    // Storage write: valid lanes land at tail, tail+1, ... modulo DEPTH.
    always_comb begin
        logic [PTR_W-1:0] wr_idx;
        logic             wr_en;
        mem_d = mem_q;
        for (int i = 0; i < FETCH_W; i++) begin
            wr_idx        = tail_q + PTR_W'(i);
            wr_en         = enq_fire_s & iq.in_valid[i];
            mem_d[wr_idx] = wr_en ? '{bd: iq.in_bd[i], data: iq.in_data[i]} : mem_d[wr_idx];
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; every read is qualified by out_valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Issue window: the ISSUE_W oldest entries, read straight from registered state.
    always_comb begin
        logic [PTR_W-1:0] rd_idx;
        for (int k = 0; k < ISSUE_W; k++) begin
            rd_idx          = head_q + PTR_W'(k);
            iq.out_valid[k] = (count_q > CNT_W'(k));
            iq.out_data[k]  = mem_q[rd_idx].data;
            iq.out_bd[k]    = mem_q[rd_idx].bd;
        end
    end

    assign iq.in_ready  = in_ready_s;
    assign iq.occupancy = count_q;

    inst_queue_chk #(
        .FETCH_W (FETCH_W),
        .AW      (AW)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .occupancy  (count_q),
        .out_accept (iq.out_accept),
        .in_valid   (iq.in_valid)
    );

endmodule
